// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared encodings for the multi-cycle RISC-V control path
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

    function automatic logic is_supported(input logic [6:0] opc);
        return (opc == OP_LOAD) || (opc == OP_STORE) || (opc == OP_R) ||
               (opc == OP_I) || (opc == OP_BRANCH) || (opc == OP_JAL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/main_fsm_out_decode.sv
// ============================================================================
// main_fsm_out_decode : Moore strobe decode for the main control FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module main_fsm_out_decode
    import riscv_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_funct7_5,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       illegal_instr
);

    logic pc_update;
    logic branch;

    always_comb begin
        alu_op        = ALUOP_ADD;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target PC+imm while the opcode resolves
                alu_src_a     = SRCA_OLDPC;
                alu_src_b     = SRCB_IMM;
                illegal_instr = ~is_supported(opcode);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

    // I-type funct7_5 is really imm[10]; only SRAI may treat it as the arithmetic bit
    assign alu_funct7_5 = funct7_5 & (alu_op == ALUOP_FUNCT) &
                          ((opcode == OP_R) | (funct3 == F3_SHIFT_RIGHT));

endmodule

`default_nettype wire

// File: rtl/main_fsm.sv
// ============================================================================
// main_fsm : multi-cycle RISC-V control FSM (state register + next state)
// Rev 1.0
// ============================================================================
`default_nettype none

module main_fsm
    import riscv_pkg::*;
#(
    parameter int unsigned WAIT_MEM = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_funct7_5,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       illegal_instr,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    logic   mem_ready_eff;

    assign mem_ready_eff = (WAIT_MEM != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready_eff ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready_eff ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready_eff ? S_FETCH : S_MEMWRITE;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    assign state = state_q;

    main_fsm_out_decode u_out_decode (
        .state         (state_q),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready_eff),
        .alu_op        (alu_op),
        .alu_funct7_5  (alu_funct7_5),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .pc_write      (pc_write),
        .illegal_instr (illegal_instr)
    );

endmodule

`default_nettype wire
